// File: rtl/nco_pwm_dac_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : nco_pwm_dac_if
//  Description : Sample/control bundle between an upstream NCO (master) and
//                the PWM audio DAC (slave). The PWM DAC asks the NCO for new
//                samples through next_sample and reports its PWM output and
//                its current duty value.
//  Revision    : 1.0  initial release
// ============================================================================
interface nco_pwm_dac_if #(
    parameter int PWM_BITS = 10
);
    logic                en;
    logic                mute;
    logic [2:0]          vol_shift;
    logic [13:0]         code;
    logic                next_sample;
    logic                pwm_out;
    logic [PWM_BITS-1:0] duty;

    // Upstream side: drives the sample and controls, consumes the request.
    modport master (
        output en,
        output mute,
        output vol_shift,
        output code,
        input  next_sample,
        input  pwm_out,
        input  duty
    );

    // DAC side.
    modport slave (
        input  en,
        input  mute,
        input  vol_shift,
        input  code,
        output next_sample,
        output pwm_out,
        output duty
    );
endinterface

`default_nettype wire

// File: rtl/nco_pwm_dac.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : nco_pwm_dac
//  Description : Two-state (IDLE/RUN) PWM DAC. While running, a free period
//                counter sweeps 0..2^PWM_BITS-1; the upstream NCO is asked for
//                the next sample three cycles before the period ends, the
//                sample is volume-scaled, converted to offset binary and
//                latched as the duty for the following period. pwm_out is high
//                while the counter is below the duty. PWM_BITS legal: 4..14.
//  Revision    : 1.0  initial release
// ============================================================================
module nco_pwm_dac #(
    parameter int PWM_BITS = 10
) (
    input  wire logic       clk,
    input  wire logic       rst,
    nco_pwm_dac_if.slave    bus
);

    // Last counter value of a period, midscale duty, and the counter value
    // at which the NCO is asked for a sample (leaves it three cycles to respond
    // before the capture edge at the end of the period).
    localparam logic [PWM_BITS-1:0] c_max     = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] c_mid     = {1'b1, {(PWM_BITS-1){1'b0}}};
    localparam logic [PWM_BITS-1:0] c_req_cnt = c_max - PWM_BITS'(2);
    localparam int                  c_drop    = 14 - PWM_BITS;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] cnt_q,   cnt_d;
    logic [PWM_BITS-1:0] duty_q,  duty_d;
    logic                pwm_q,   pwm_d;
    logic                req_q,   req_d;

    logic signed [13:0]  w_scaled;
    logic [13:0]         w_offset;
    logic [PWM_BITS-1:0] w_new_duty;

    // Sample transform: volume shift (sign-preserving), flip the sign bit to
    // get offset binary, keep the top PWM_BITS bits as the new duty.
    always_comb begin
        w_scaled   = $signed(bus.code) >>> bus.vol_shift;
        w_offset   = w_scaled ^ 14'h2000;
        w_new_duty = PWM_BITS'(w_offset >> c_drop);
    end

    // Next-state logic: run/idle control, period counter and duty latch; the
    // registered pwm/request bits are computed from the next counter and duty
    // so they line up with the cycle in which that counter value is current.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        duty_d  = c_mid;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.en) begin
                    // Abandon the period; the restart begins at midscale.
                    state_d = IDLE;
                end else begin
                    cnt_d  = cnt_q + PWM_BITS'(1);
                    duty_d = duty_q;
                    if (cnt_q == c_max) begin
                        duty_d = bus.mute ? c_mid : w_new_duty;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        pwm_d = (state_d == RUN) && (cnt_d < duty_d);
        req_d = (state_d == RUN) && (cnt_d == c_req_cnt);
    end

    // State and output registers; reset takes effect without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            duty_q  <= c_mid;
            pwm_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            pwm_q   <= pwm_d;
            req_q   <= req_d;
        end
    end

    // A request whose cycle coincides with en going low is withdrawn, since
    // the period it belongs to is being abandoned.
    assign bus.next_sample = req_q & bus.en;
    assign bus.pwm_out     = pwm_q;
    assign bus.duty        = duty_q;

endmodule

`default_nettype wire

// File: tb/tb_nco_pwm_dac.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_nco_pwm_dac
//  Description : Testbench for nco_pwm_dac (PWM_BITS = 10). Stimulus pushes the
//                expected duty / high-cycle count of each PWM period into a
//                queue; an independent monitor pops and checks it when the
//                period completes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nco_pwm_dac;

    localparam int PWM_BITS = 10;
    localparam int PERIOD   = 1024;
    localparam int FIRST_PULSE = 1021;

    logic clk = 1'b0;
    logic rst = 1'b1;

    nco_pwm_dac_if #(.PWM_BITS(PWM_BITS)) bus ();

    nco_pwm_dac #(.PWM_BITS(PWM_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 125 MHz
    always #4 clk = ~clk;

    typedef struct {
        int duty;
        int hi;
    } exp_t;

    typedef struct {
        logic [13:0] code;
        logic [2:0]  vs;
        logic        m;
        int          duty;
    } vec_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Directed sample vectors; duty values hand-computed from the transform.
    vec_t vecs [0:11] = '{
        '{14'h0000, 3'd0, 1'b0, 512},
        '{14'h1FFF, 3'd0, 1'b0, 1023},
        '{14'h2000, 3'd0, 1'b0, 0},
        '{14'h2000, 3'd1, 1'b0, 256},
        '{14'h1FFF, 3'd0, 1'b1, 512},
        '{14'h1000, 3'd2, 1'b0, 576},
        '{14'h3FFF, 3'd7, 1'b0, 511},
        '{14'h0ABC, 3'd0, 1'b0, 683},
        '{14'h0C8C, 3'd0, 1'b0, 712},
        '{14'h3374, 3'd0, 1'b0, 311},
        '{14'h1FFF, 3'd3, 1'b0, 575},
        '{14'h2000, 3'd7, 1'b0, 508}
    };

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: accumulate pwm high cycles per period; a period ends two
    // cycles after its next_sample pulse, at which point it is scored.
    initial begin : monitor
        int   acc;
        int   tail;
        int   since;
        int   duty_seen;
        bit   have_last;
        exp_t e;
        acc = 0; tail = 0; since = 0; duty_seen = 0; have_last = 0;
        forever begin
            @(negedge clk);
            if (rst || !bus.en) begin
                acc = 0; tail = 0; since = 0; have_last = 0;
            end else begin
                acc   += int'(bus.pwm_out);
                since++;
                if (tail > 0) begin
                    tail--;
                    if (tail == 0) begin
                        if (exp_q.size() == 0) begin
                            chk("period_unexpected", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("period_duty", duty_seen, e.duty);
                            chk("period_high_cycles", acc, e.hi);
                        end
                        acc = 0;
                    end
                end
                if (bus.next_sample) begin
                    if (have_last) chk("pulse_spacing", since, PERIOD);
                    since     = 0;
                    have_last = 1;
                    tail      = 2;
                    duty_seen = int'(bus.duty);
                end
            end
        end
    end

    // Wait (bounded) for the next next_sample pulse; n counts negedges.
    task automatic wait_pulse(output int n, output bit ok);
        ok = 0;
        n  = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (bus.next_sample) begin
                n  = i;
                ok = 1;
                break;
            end
        end
        if (!ok) chk("pulse_timeout", 0, 1);
    endtask

    // Answer a sample request like an NCO would, queue the expectation for
    // the period it will drive, then scramble inputs after the capture edge.
    task automatic feed(input logic [13:0] c, input logic [2:0] vs, input logic m,
                        input int exp_duty, input int exp_first);
        int n;
        bit ok;
        wait_pulse(n, ok);
        if (ok && exp_first >= 0) chk("first_pulse_index", n, exp_first);
        bus.code      = c;
        bus.vol_shift = vs;
        bus.mute      = m;
        exp_q.push_back('{exp_duty, exp_duty});
        repeat (4) @(negedge clk);
        bus.code      = 14'($urandom);
        bus.vol_shift = 3'($urandom);
        bus.mute      = 1'($urandom);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pwm"},  int'(bus.pwm_out),     0);
        chk({tag, "_req"},  int'(bus.next_sample), 0);
        chk({tag, "_duty"}, int'(bus.duty),        512);
    endtask

    initial begin : stim
        int n;
        bit ok;
        bit bad;
        bus.en        = 1'b0;
        bus.mute      = 1'b0;
        bus.vol_shift = 3'd0;
        bus.code      = 14'h0000;

        // Reset state, then stays idle with en low after release.
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("post_reset_idle");

        // Run through directed vectors; first period is midscale.
        exp_q.push_back('{512, 512});
        bus.en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            feed(vecs[i].code, vecs[i].vs, vecs[i].m, vecs[i].duty,
                 (i == 0) ? FIRST_PULSE : -1);
        end
        // Let the last directed period complete, then drop en at cnt = 500.
        wait_pulse(n, ok);
        repeat (503) @(negedge clk);
        bus.en = 1'b0;
        exp_q.delete();
        bad = 0;
        repeat (37) begin
            @(negedge clk);
            if (bus.pwm_out !== 1'b0 || bus.next_sample !== 1'b0 || bus.duty !== 10'd512)
                bad = 1;
        end
        chk("idle_window_clean", int'(bad), 0);

        // Restart: midscale first period, then full-scale.
        exp_q.push_back('{512, 512});
        bus.en = 1'b1;
        feed(14'h1FFF, 3'd0, 1'b0, 1023, FIRST_PULSE);
        repeat (499) @(negedge clk);
        chk("pre_reset_pwm",  int'(bus.pwm_out), 1);
        chk("pre_reset_duty", int'(bus.duty),    1023);
        // Asynchronous reset mid-period, checked before any clock edge.
        #2;
        rst    = 1'b1;
        bus.en = 1'b0;
        exp_q.delete();
        #1;
        chk_idle("async_reset");
        #10;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("after_async_reset");

        // en falling in the request cycle withdraws the request.
        exp_q.push_back('{512, 512});
        bus.en = 1'b1;
        feed(14'h2000, 3'd0, 1'b0, 0, FIRST_PULSE);
        repeat (1019) @(negedge clk);
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("req_suppressed", int'(bus.next_sample), 0);
        @(negedge clk);
        chk_idle("idle_after_drop");

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nco_pwm_dac.md
NCO_PWM_DAC -- requirements
Module: nco_pwm_dac

Interface
REQ-001 Parameter PWM_BITS, default 10, PWM resolution and sample-period exponent; legal range 4..14.
REQ-002 Port clk  input  1  system clock (125 MHz).
REQ-003 Port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 Port en  input  1  run enable; low forces IDLE.
REQ-005 Port mute  input  1  forces midscale duty at next capture.
REQ-006 Port vol_shift  input  3  arithmetic right-shift amount applied to code (0..7).
REQ-007 Port code  input  14  signed two's-complement sample from upstream NCO.
REQ-008 Port next_sample  output  1  one-cycle request to NCO to advance to next sample.
REQ-009 Port pwm_out  output  1  PWM bitstream to audio filter/pin.
REQ-010 Port duty  output  PWM_BITS  duty value currently applied (debug/observe).

Function
REQ-011 Block SHALL implement two states: IDLE and RUN; MAX = 2^PWM_BITS - 1.
REQ-012 IDLE -> RUN on a clock edge with en=1; RUN -> IDLE on a clock edge with en=0.
REQ-013 In IDLE: period counter cnt = 0, pwm_out = 0, next_sample = 0, duty = 2^(PWM_BITS-1).
REQ-014 In RUN: cnt increments by 1 every cycle, wraps MAX -> 0; first RUN cycle has cnt = 0.
REQ-015 next_sample SHALL be high for exactly the one cycle in which cnt == MAX-2, else low; one pulse per 2^PWM_BITS cycles.
REQ-016 code SHALL be captured only at the clock edge ending the cnt == MAX cycle; code changes at any other time are ignored.
REQ-017 Capture transform: s = code >>> vol_shift (sign-extended); u = s with bit 13 inverted (offset binary); new duty = u[13:14-PWM_BITS].
REQ-018 If mute=1 at the capture edge, new duty = 2^(PWM_BITS-1) regardless of code/vol_shift.
REQ-019 New duty SHALL take effect for the period starting at the following cnt == 0 cycle and hold for the full period.
REQ-020 pwm_out SHALL be a registered output equal to (cnt < duty) during each RUN cycle; duty 0 -> never high, duty MAX -> high MAX of 2^PWM_BITS cycles.
REQ-021 duty output SHALL equal the duty used for the current PWM period.
REQ-022 en falling mid-period: next cycle is IDLE per REQ-013; no next_sample issued, pending period abandoned.
REQ-023 en rising again: RUN restarts at cnt = 0 with midscale duty for the first period.
REQ-024 en=0 on the cycle where cnt == MAX-2: next_sample SHALL NOT assert.

Reset
REQ-025 rst=1 SHALL immediately (asynchronously) force IDLE, cnt = 0, duty = 2^(PWM_BITS-1), pwm_out = 0, next_sample = 0.
REQ-026 After rst deasserts, block SHALL leave IDLE only on a clock edge with en=1; reset mid-period behaves as REQ-025 with no partial pulse on next_sample.

Verification (PWM_BITS = 10)
REQ-027 Reset, en=1 held: next_sample pulses once every 1024 cycles, first pulse in the cycle where cnt = 1021; no double pulses over 10 periods.
REQ-028 code = 0x0000, vol_shift = 0: duty = 512, pwm_out high exactly 512 of 1024 cycles per period.
REQ-029 code = 0x1FFF -> duty = 1023, pwm_out high 1023 of 1024 cycles; code = 0x2000 -> duty = 0, pwm_out never high.
REQ-030 code = 0x2000, vol_shift = 1: s = 0x3000, duty = 256; mute = 1 with code = 0x1FFF: duty = 512.
REQ-031 Hook to nco with fcw = 0x10000: captured codes match LUT[1], LUT[2], ... in order, one per period; code toggled between captures has no effect on duty.
REQ-032 en deasserted at cnt = 500, re-asserted 37 cycles later: pwm_out = 0 and no next_sample while IDLE; RUN resumes at cnt = 0, duty = 512; async rst pulse mid-period gives the same IDLE values with no clock edge.
